// File: rtl/eeprom_i2c_ctrl.sv
// Bus-slave front end for 24LCxx-family I2C EEPROMs. Single-byte bus reads and
// writes are turned into byte-level commands for an external I2C engine.
// Writes are posted and followed by ACK polling. One extra request can be
// queued while a transaction is in flight.
module eeprom_i2c_ctrl #(
  parameter int unsigned ADDRESS           = 0,
  parameter int unsigned BUS_ADDR_DATA_LEN = 16,
  parameter int unsigned EEPROM_SIZE       = 'h80,
  parameter int unsigned ADDR_BYTES        = 2,
  parameter logic [2:0]  CHIP_SEL          = 3'b000,
  parameter int unsigned POLL_MAX          = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         rd,
  input  logic                         wr,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic                         req_bus,
  output logic                         stall,
  output logic                         busy,
  output logic                         err,
  input  logic                         err_clr,
  output logic                         eng_go,
  output logic [2:0]                   eng_cmd,
  output logic [7:0]                   eng_tx,
  input  logic                         eng_busy,
  input  logic                         eng_nack,
  input  logic [7:0]                   eng_rx
);

  localparam int POLL_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [63:0] WIN_LO = 64'(ADDRESS);
  localparam logic [63:0] WIN_HI = 64'(ADDRESS) + 64'(EEPROM_SIZE);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] BASE = BUS_ADDR_DATA_LEN'(ADDRESS);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_W, S_A_HI, S_A_LO, S_R_DEV, S_R_DATA, S_W_DATA, S_POLL, S_ERR_STOP
  } state_t;

  state_t              r_state, w_state_nx;
  logic                r_wait, w_wait_nx;
  logic                r_busy_q;
  logic [15:0]         r_off, w_off_nx;
  logic [7:0]          r_data, w_data_nx;
  logic                r_rd, w_rd_nx;
  logic                r_pnd_vld, w_pnd_vld_nx;
  logic [15:0]         r_pnd_off, w_pnd_off_nx;
  logic [7:0]          r_pnd_data, w_pnd_data_nx;
  logic                r_pnd_rd, w_pnd_rd_nx;
  logic [POLL_W-1:0]   r_cnt, w_cnt_nx;
  logic [7:0]          r_bus_out, w_bus_out_nx;
  logic                r_stall, w_stall_nx;
  logic                r_err, w_err_nx;
  logic                r_go, w_go_nx;
  logic [2:0]          r_cmd, w_cmd_nx;
  logic [7:0]          r_tx, w_tx_nx;

  logic [63:0]                  w_addr64;
  logic [BUS_ADDR_DATA_LEN-1:0] w_off_bus;
  logic [15:0]                  w_off;
  logic                         w_req;
  logic                         w_fall;
  logic                         w_done;
  logic                         w_set_err;

  // Device byte: block bits come from the offset for 1-byte parts, chip pins otherwise.
  function automatic logic [7:0] dev_byte(input logic [2:0] blk, input logic rw);
    return {4'b1010, (ADDR_BYTES == 1) ? blk : CHIP_SEL, rw};
  endfunction

  assign w_addr64  = 64'(addr);
  assign req_bus   = (w_addr64 >= WIN_LO) && (w_addr64 < WIN_HI);
  assign w_off_bus = addr - BASE;
  assign w_off     = 16'(w_off_bus);
  assign w_req     = (rd | wr) & req_bus;
  assign w_fall    = r_wait & r_busy_q & ~eng_busy;

  assign bus_out = r_bus_out;
  assign stall   = r_stall;
  assign busy    = (r_state != S_IDLE);
  assign err     = r_err;
  assign eng_go  = r_go;
  assign eng_cmd = r_cmd;
  assign eng_tx  = r_tx;

  // Next-state, engine command and bus-side bookkeeping.
  always_comb begin
    w_state_nx    = r_state;
    w_wait_nx     = r_wait;
    w_off_nx      = r_off;
    w_data_nx     = r_data;
    w_rd_nx       = r_rd;
    w_pnd_vld_nx  = r_pnd_vld;
    w_pnd_off_nx  = r_pnd_off;
    w_pnd_data_nx = r_pnd_data;
    w_pnd_rd_nx   = r_pnd_rd;
    w_cnt_nx      = r_cnt;
    w_bus_out_nx  = r_bus_out;
    w_stall_nx    = r_stall;
    w_go_nx       = 1'b0;
    w_cmd_nx      = r_cmd;
    w_tx_nx       = r_tx;
    w_done        = 1'b0;
    w_set_err     = 1'b0;

    if (r_state == S_IDLE) begin
      // A queued request always goes before a fresh one; stall is already high for it.
      if (r_pnd_vld) begin
        w_off_nx     = r_pnd_off;
        w_data_nx    = r_pnd_data;
        w_rd_nx      = r_pnd_rd;
        w_pnd_vld_nx = 1'b0;
        w_state_nx   = S_DEV_W;
        w_wait_nx    = 1'b0;
      end else if (w_req) begin
        w_off_nx   = w_off;
        w_data_nx  = bus_in;
        w_rd_nx    = rd;
        w_stall_nx = rd;
        w_state_nx = S_DEV_W;
        w_wait_nx  = 1'b0;
      end
    end else if (!r_wait) begin
      // Launch this state's byte once the engine is free.
      if (!eng_busy) begin
        w_go_nx   = 1'b1;
        w_wait_nx = 1'b1;
        case (r_state)
          S_DEV_W:    begin w_cmd_nx = 3'd1; w_tx_nx = dev_byte(r_off[10:8], 1'b0); end
          S_A_HI:     begin w_cmd_nx = 3'd2; w_tx_nx = r_off[15:8]; end
          S_A_LO:     begin w_cmd_nx = 3'd2; w_tx_nx = r_off[7:0]; end
          S_R_DEV:    begin w_cmd_nx = 3'd1; w_tx_nx = dev_byte(r_off[10:8], 1'b1); end
          S_R_DATA:   begin w_cmd_nx = 3'd4; w_tx_nx = 8'h00; end
          S_W_DATA:   begin w_cmd_nx = 3'd3; w_tx_nx = r_data; end
          S_POLL:     begin w_cmd_nx = 3'd5; w_tx_nx = dev_byte(r_off[10:8], 1'b0); end
          S_ERR_STOP: begin w_cmd_nx = 3'd6; w_tx_nx = 8'h00; end
          default:    begin w_cmd_nx = 3'd0; w_tx_nx = 8'h00; end
        endcase
      end
    end else if (w_fall) begin
      // Engine finished the byte: act on its ACK/NACK and data.
      w_wait_nx = 1'b0;
      case (r_state)
        S_DEV_W: begin
          if (eng_nack) begin w_state_nx = S_ERR_STOP; w_set_err = 1'b1; end
          else w_state_nx = (ADDR_BYTES == 2) ? S_A_HI : S_A_LO;
        end
        S_A_HI: begin
          if (eng_nack) begin w_state_nx = S_ERR_STOP; w_set_err = 1'b1; end
          else w_state_nx = S_A_LO;
        end
        S_A_LO: begin
          if (eng_nack) begin w_state_nx = S_ERR_STOP; w_set_err = 1'b1; end
          else w_state_nx = r_rd ? S_R_DEV : S_W_DATA;
        end
        S_R_DEV: begin
          if (eng_nack) begin w_state_nx = S_ERR_STOP; w_set_err = 1'b1; end
          else w_state_nx = S_R_DATA;
        end
        S_R_DATA: begin
          w_bus_out_nx = eng_rx;
          w_done       = 1'b1;
        end
        S_W_DATA: begin
          if (eng_nack) begin w_state_nx = S_ERR_STOP; w_set_err = 1'b1; end
          else begin w_state_nx = S_POLL; w_cnt_nx = '0; end
        end
        S_POLL: begin
          if (!eng_nack) w_done = 1'b1;
          else if (r_cnt == POLL_LAST) begin w_set_err = 1'b1; w_done = 1'b1; end
          else w_cnt_nx = r_cnt + 1'b1;
        end
        S_ERR_STOP: begin
          if (r_rd) w_bus_out_nx = 8'hFF;
          w_done = 1'b1;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end

    // Stall stays up across the current transaction while a queued one still waits.
    if (w_done) begin
      w_state_nx = S_IDLE;
      if (!r_pnd_vld) w_stall_nx = 1'b0;
    end

    // Request arriving mid-transaction takes the single pending slot.
    if ((r_state != S_IDLE) && !r_stall && w_req) begin
      w_pnd_vld_nx  = 1'b1;
      w_pnd_off_nx  = w_off;
      w_pnd_data_nx = bus_in;
      w_pnd_rd_nx   = rd;
      w_stall_nx    = 1'b1;
    end

    w_err_nx = w_set_err ? 1'b1 : (err_clr ? 1'b0 : r_err);
  end

  // State and output registers; payload registers carry no reset.
  always_ff @(posedge clk) begin
    r_off      <= w_off_nx;
    r_data     <= w_data_nx;
    r_pnd_off  <= w_pnd_off_nx;
    r_pnd_data <= w_pnd_data_nx;
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= 1'b0;
      r_busy_q  <= 1'b0;
      r_rd      <= 1'b0;
      r_pnd_vld <= 1'b0;
      r_pnd_rd  <= 1'b0;
      r_cnt     <= '0;
      r_bus_out <= 8'h00;
      r_stall   <= 1'b0;
      r_err     <= 1'b0;
      r_go      <= 1'b0;
      r_cmd     <= 3'd0;
      r_tx      <= 8'h00;
    end else begin
      r_state   <= w_state_nx;
      r_wait    <= w_wait_nx;
      r_busy_q  <= eng_busy;
      r_rd      <= w_rd_nx;
      r_pnd_vld <= w_pnd_vld_nx;
      r_pnd_rd  <= w_pnd_rd_nx;
      r_cnt     <= w_cnt_nx;
      r_bus_out <= w_bus_out_nx;
      r_stall   <= w_stall_nx;
      r_err     <= w_err_nx;
      r_go      <= w_go_nx;
      r_cmd     <= w_cmd_nx;
      r_tx      <= w_tx_nx;
    end
  end

endmodule

// File: tb/tb_eeprom_i2c_ctrl.sv
// Bench for eeprom_i2c_ctrl: two configurations (2-byte addressing at 0x100 with
// POLL_MAX=4, 1-byte addressing at 0 with a 2 KiB window) driven against a
// behavioural byte-level I2C engine that logs every command it receives.
module tb_eeprom_i2c_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0][15:0]    addr_w;
  logic [1:0]          rd_w, wr_w, err_clr_w;
  logic [1:0][7:0]     bus_in_w;
  logic [1:0][7:0]     bus_out_w;
  logic [1:0]          req_w, stall_w, busy_w, err_w, go_w;
  logic [1:0][2:0]     cmd_w;
  logic [1:0][7:0]     tx_w;
  logic [1:0]          m_busy, m_nack;
  logic [1:0][7:0]     m_rx;

  eeprom_i2c_ctrl #(.ADDRESS('h100), .BUS_ADDR_DATA_LEN(16), .EEPROM_SIZE('h80),
                    .ADDR_BYTES(2), .CHIP_SEL(3'b000), .POLL_MAX(4)) u_dut0 (
    .clk(clk), .rst(rst), .addr(addr_w[0]), .rd(rd_w[0]), .wr(wr_w[0]),
    .bus_in(bus_in_w[0]), .bus_out(bus_out_w[0]), .req_bus(req_w[0]),
    .stall(stall_w[0]), .busy(busy_w[0]), .err(err_w[0]), .err_clr(err_clr_w[0]),
    .eng_go(go_w[0]), .eng_cmd(cmd_w[0]), .eng_tx(tx_w[0]),
    .eng_busy(m_busy[0]), .eng_nack(m_nack[0]), .eng_rx(m_rx[0]));

  eeprom_i2c_ctrl #(.ADDRESS(0), .BUS_ADDR_DATA_LEN(16), .EEPROM_SIZE('h800),
                    .ADDR_BYTES(1), .CHIP_SEL(3'b000), .POLL_MAX(255)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr_w[1]), .rd(rd_w[1]), .wr(wr_w[1]),
    .bus_in(bus_in_w[1]), .bus_out(bus_out_w[1]), .req_bus(req_w[1]),
    .stall(stall_w[1]), .busy(busy_w[1]), .err(err_w[1]), .err_clr(err_clr_w[1]),
    .eng_go(go_w[1]), .eng_cmd(cmd_w[1]), .eng_tx(tx_w[1]),
    .eng_busy(m_busy[1]), .eng_nack(m_nack[1]), .eng_rx(m_rx[1]));

  // Engine model state
  int         cyc = 0;
  int         log_n [2] = '{0, 0};
  logic [2:0] log_cmd [2][256];
  logic [7:0] log_tx  [2][256];
  logic [2:0] cur_cmd [2] = '{3'd0, 3'd0};
  int         tmr [2] = '{0, 0};
  int         poll_cnt [2] = '{0, 0};
  int         viol [2] = '{0, 0};
  int         fall_cyc [2] = '{0, 0};

  // Engine knobs set by the stimulus
  logic       nack_dev [2];
  int         poll_nacks [2];
  logic [7:0] rx_val [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural engine: busy for 3 cycles per command, NACK/data valid at busy fall.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i]   <= 1'b0;
        m_nack[i]   <= 1'b0;
        m_rx[i]     <= 8'h00;
        tmr[i]      <= 0;
        poll_cnt[i] <= 0;
      end else if (go_w[i]) begin
        if (m_busy[i]) viol[i] <= viol[i] + 1;
        if (log_n[i] < 256) begin
          log_cmd[i][log_n[i]] <= cmd_w[i];
          log_tx[i][log_n[i]]  <= tx_w[i];
        end
        log_n[i]   <= log_n[i] + 1;
        cur_cmd[i] <= cmd_w[i];
        m_busy[i]  <= 1'b1;
        tmr[i]     <= 2;
      end else if (m_busy[i]) begin
        if (tmr[i] == 0) begin
          m_busy[i]   <= 1'b0;
          fall_cyc[i] <= cyc + 1;
          m_rx[i]     <= (cur_cmd[i] == 3'd4) ? rx_val[i] : 8'h00;
          if (cur_cmd[i] == 3'd1) m_nack[i] <= nack_dev[i];
          else if (cur_cmd[i] == 3'd5) begin
            if (poll_cnt[i] < poll_nacks[i]) begin
              m_nack[i]   <= 1'b1;
              poll_cnt[i] <= poll_cnt[i] + 1;
            end else begin
              m_nack[i]   <= 1'b0;
              poll_cnt[i] <= 0;
            end
          end else m_nack[i] <= 1'b0;
        end else tmr[i] <= tmr[i] - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [15:0] a, input logic r, input logic w,
                       input logic [7:0] d);
    addr_w[i]   = a;
    rd_w[i]     = r;
    wr_w[i]     = w;
    bus_in_w[i] = d;
    tick();
    rd_w[i] = 1'b0;
    wr_w[i] = 1'b0;
  endtask

  // sel 0 waits for stall low, sel 1 for busy low; reports whether stall was seen high.
  task automatic wait_low(input int i, input int sel, input int bound, input string name,
                          output logic saw_stall);
    int k;
    k = 0;
    saw_stall = 1'b0;
    while (((sel == 0) ? stall_w[i] : busy_w[i]) !== 1'b0 && k < bound) begin
      tick();
      if (stall_w[i] === 1'b1) saw_stall = 1'b1;
      k++;
    end
    if (k >= bound) check({name, " timeout"}, 32'((sel == 0) ? stall_w[i] : busy_w[i]), 0);
  endtask

  task automatic wait_log(input int i, input int n, input int bound);
    int k;
    k = 0;
    while (log_n[i] < n && k < bound) begin
      tick();
      k++;
    end
    if (log_n[i] < n) check("log wait timeout", log_n[i], n);
  endtask

  task automatic check_go(input int i, input int idx, input logic [2:0] cmd,
                          input logic [7:0] tx, input logic chk_tx);
    if (idx >= log_n[i]) check($sformatf("go%0d[%0d] missing", i, idx), log_n[i], idx + 1);
    else begin
      check($sformatf("go%0d[%0d] cmd", i, idx), 32'(log_cmd[i][idx]), 32'(cmd));
      if (chk_tx) check($sformatf("go%0d[%0d] tx", i, idx), 32'(log_tx[i][idx]), 32'(tx));
    end
  endtask

  task automatic check_reset(input int i, input string tag);
    check({tag, " bus_out"}, 32'(bus_out_w[i]), 0);
    check({tag, " stall"},   32'(stall_w[i]), 0);
    check({tag, " busy"},    32'(busy_w[i]), 0);
    check({tag, " err"},     32'(err_w[i]), 0);
    check({tag, " eng_go"},  32'(go_w[i]), 0);
    check({tag, " eng_cmd"}, 32'(cmd_w[i]), 0);
    check({tag, " eng_tx"},  32'(tx_w[i]), 0);
  endtask

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic        exp_req;
  } dec_vec_t;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    dec_vec_t dec_tab [8];
    int   base;
    int   npoll;
    logic saw;

    dec_tab[0] = '{0, 16'h00FF, 1'b0};
    dec_tab[1] = '{0, 16'h0100, 1'b1};
    dec_tab[2] = '{0, 16'h0123, 1'b1};
    dec_tab[3] = '{0, 16'h017F, 1'b1};
    dec_tab[4] = '{0, 16'h0180, 1'b0};
    dec_tab[5] = '{1, 16'h0000, 1'b1};
    dec_tab[6] = '{1, 16'h07FF, 1'b1};
    dec_tab[7] = '{1, 16'h0800, 1'b0};

    rst = 1'b1;
    rd_w = '0; wr_w = '0; err_clr_w = '0; addr_w = '0; bus_in_w = '0;
    nack_dev   = '{1'b0, 1'b0};
    poll_nacks = '{0, 0};
    rx_val     = '{8'h00, 8'h00};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // Reset values
    check_reset(0, "reset0");
    check_reset(1, "reset1");

    // Window decode table
    for (int t = 0; t < 8; t++) begin
      addr_w[dec_tab[t].inst] = dec_tab[t].a;
      #1;
      check($sformatf("req_bus[%0d] @%h", dec_tab[t].inst, dec_tab[t].a),
            32'(req_w[dec_tab[t].inst]), 32'(dec_tab[t].exp_req));
    end
    tick();

    // 1: two-byte addressed read at 0x123
    base = log_n[0];
    rx_val[0] = 8'h5A;
    issue(0, 16'h0123, 1'b1, 1'b0, 8'h00);
    check("s1 stall after accept", 32'(stall_w[0]), 1);
    check("s1 busy after accept", 32'(busy_w[0]), 1);
    wait_low(0, 0, 300, "s1 read", saw);
    check("s1 stall lag", cyc - fall_cyc[0], 1);
    check("s1 go count", log_n[0] - base, 5);
    check_go(0, base + 0, 3'd1, 8'hA0, 1'b1);
    check_go(0, base + 1, 3'd2, 8'h00, 1'b1);
    check_go(0, base + 2, 3'd2, 8'h23, 1'b1);
    check_go(0, base + 3, 3'd1, 8'hA1, 1'b1);
    check_go(0, base + 4, 3'd4, 8'h00, 1'b0);
    check("s1 bus_out", 32'(bus_out_w[0]), 32'h5A);
    check("s1 busy end", 32'(busy_w[0]), 0);
    check("s1 err", 32'(err_w[0]), 0);

    // 2: one-byte addressed posted write with 3 poll NACKs
    base = log_n[1];
    poll_nacks[1] = 3;
    issue(1, 16'h02F7, 1'b0, 1'b1, 8'h3C);
    check("s2 stall after accept", 32'(stall_w[1]), 0);
    check("s2 busy after accept", 32'(busy_w[1]), 1);
    wait_low(1, 1, 600, "s2 write", saw);
    check("s2 stall during write", 32'(saw), 0);
    check("s2 go count", log_n[1] - base, 7);
    check_go(1, base + 0, 3'd1, 8'hA4, 1'b1);
    check_go(1, base + 1, 3'd2, 8'hF7, 1'b1);
    check_go(1, base + 2, 3'd3, 8'h3C, 1'b1);
    for (int k = 3; k < 7; k++) check_go(1, base + k, 3'd5, 8'hA4, 1'b1);
    check("s2 err", 32'(err_w[1]), 0);

    // 3: read queued behind the posted write
    base = log_n[1];
    poll_nacks[1] = 3;
    rx_val[1] = 8'hC3;
    issue(1, 16'h02F7, 1'b0, 1'b1, 8'h3C);
    repeat (3) tick();
    issue(1, 16'h0200, 1'b1, 1'b0, 8'h00);
    check("s3 stall pending", 32'(stall_w[1]), 1);
    check("s3 busy pending", 32'(busy_w[1]), 1);
    wait_low(1, 0, 1200, "s3 queued read", saw);
    check("s3 go count at stall fall", log_n[1] - base, 11);
    check_go(1, base + 6,  3'd5, 8'hA4, 1'b1);
    check_go(1, base + 7,  3'd1, 8'hA4, 1'b1);
    check_go(1, base + 8,  3'd2, 8'h00, 1'b1);
    check_go(1, base + 9,  3'd1, 8'hA5, 1'b1);
    check_go(1, base + 10, 3'd4, 8'h00, 1'b0);
    check("s3 stall lag", cyc - fall_cyc[1], 1);
    check("s3 bus_out", 32'(bus_out_w[1]), 32'hC3);
    check("s3 busy end", 32'(busy_w[1]), 0);

    // 4: device byte NACKed on a read
    base = log_n[0];
    nack_dev[0] = 1'b1;
    issue(0, 16'h0105, 1'b1, 1'b0, 8'h00);
    wait_low(0, 0, 300, "s4 nack read", saw);
    check("s4 go count", log_n[0] - base, 2);
    check_go(0, base + 0, 3'd1, 8'hA0, 1'b1);
    check_go(0, base + 1, 3'd6, 8'h00, 1'b0);
    check("s4 bus_out", 32'(bus_out_w[0]), 32'hFF);
    check("s4 err set", 32'(err_w[0]), 1);
    check("s4 busy end", 32'(busy_w[0]), 0);
    nack_dev[0] = 1'b0;
    err_clr_w[0] = 1'b1;
    tick();
    err_clr_w[0] = 1'b0;
    check("s4 err cleared", 32'(err_w[0]), 0);

    // 5: poll timeout with POLL_MAX=4
    base = log_n[0];
    poll_nacks[0] = 1000;
    issue(0, 16'h0110, 1'b0, 1'b1, 8'h77);
    wait_low(0, 1, 600, "s5 poll timeout", saw);
    npoll = 0;
    for (int k = base; k < log_n[0] && k < 256; k++) if (log_cmd[0][k] == 3'd5) npoll++;
    check("s5 poll count", npoll, 4);
    check("s5 go count", log_n[0] - base, 8);
    check_go(0, base + 0, 3'd1, 8'hA0, 1'b1);
    check_go(0, base + 1, 3'd2, 8'h00, 1'b1);
    check_go(0, base + 2, 3'd2, 8'h10, 1'b1);
    check_go(0, base + 3, 3'd3, 8'h77, 1'b1);
    check("s5 err", 32'(err_w[0]), 1);
    check("s5 busy", 32'(busy_w[0]), 0);
    repeat (10) tick();
    check("s5 no extra go", log_n[0] - base, 8);
    poll_nacks[0] = 0;
    err_clr_w[0] = 1'b1;
    tick();
    err_clr_w[0] = 1'b0;
    check("s5 err cleared", 32'(err_w[0]), 0);

    // 6: reset during A_LO, then a normal read with rd and wr both high
    base = log_n[0];
    rx_val[0] = 8'h11;
    issue(0, 16'h0123, 1'b1, 1'b0, 8'h00);
    wait_log(0, base + 3, 300);
    rst = 1'b1;
    tick();
    check_reset(0, "s6 mid-reset");
    rst = 1'b0;
    tick();
    base = log_n[0];
    issue(0, 16'h0123, 1'b1, 1'b1, 8'h99);
    check("s6 stall rd wins", 32'(stall_w[0]), 1);
    wait_low(0, 0, 300, "s6 read", saw);
    check("s6 go count", log_n[0] - base, 5);
    check_go(0, base + 2, 3'd2, 8'h23, 1'b1);
    check_go(0, base + 3, 3'd1, 8'hA1, 1'b1);
    check_go(0, base + 4, 3'd4, 8'h00, 1'b0);
    check("s6 bus_out", 32'(bus_out_w[0]), 32'h11);
    check("s6 err", 32'(err_w[0]), 0);

    // Out-of-window access is ignored
    base = log_n[0];
    addr_w[0] = 16'h0200;
    rd_w[0] = 1'b1;
    #1;
    check("oow req_bus", 32'(req_w[0]), 0);
    repeat (3) tick();
    rd_w[0] = 1'b0;
    tick();
    check("oow no go", log_n[0] - base, 0);
    check("oow busy", 32'(busy_w[0]), 0);
    check("oow stall", 32'(stall_w[0]), 0);

    check("eng go while busy 0", viol[0], 0);
    check("eng go while busy 1", viol[1], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
